// File: rtl/fuzz_stim_gen.sv
// Stimulus generator: 34-bit Fibonacci LFSR vectors for a flat DUT input bus, N vectors per start.
// Latency: first vector valid the cycle after start is accepted; one vector per clock at full rate.
// Backpressure: vec_valid/in_flat held stable while vec_ready is low; LFSR steps only on a handshake.
// Optional feature macro: CORNER_INJECT_EN (every 8th vector replaced by a rotating corner pattern).
module fuzz_stim_gen #(
   parameter logic [33:0] SEED  = 34'h0_0000_0001,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             seed_load,
   input  logic [33:0]      seed,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             vec_ready,
   output logic             vec_valid,
   output logic [33:0]      in_flat,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // A zero seed would lock the LFSR; fall back to 1 in that case.
   localparam logic [33:0] SEED_SAFE = (SEED == 34'h0) ? 34'h1 : SEED;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [33:0]      lfsr;
   logic [33:0]      lfsr_step;
   logic [CNT_W-1:0] num_lat;
   logic             accept_start;
   logic             hs;
   logic             last_hs;
   logic             lfsr_adv;

   // Handshake: vec_valid is exactly "state is RUN", so use the state directly.
   assign hs      = (state == S_RUN) && vec_ready;
   assign last_hs = hs && (vec_cnt == (num_lat - CNT_ONE));

   // Polynomial x^34+x^27+x^2+x+1, shifting toward the MSB.
   assign lfsr_step = {lfsr[32:0], lfsr[33] ^ lfsr[26] ^ lfsr[1] ^ lfsr[0]};

`ifdef CORNER_INJECT_EN
   logic [1:0]  corner_ptr;
   logic        corner_sel;
   logic [33:0] corner_pat;

   // Every vector whose index ends in 3'b111 is replaced by a corner pattern.
   assign corner_sel = (state == S_RUN) && (vec_cnt[2:0] == 3'b111);

   // Corner pattern table indexed by the rotating pointer.
   always_comb begin
      corner_pat = 34'h0;
      case (corner_ptr)
         2'd0:    corner_pat = 34'h0_0000_0000;
         2'd1:    corner_pat = 34'h3_FFFF_FFFF;
         2'd2:    corner_pat = 34'h2_AAAA_AAAA;
         default: corner_pat = 34'h1_5555_5555;
      endcase
   end

   // Pointer restarts on each run and advances only when a corner vector is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corner_ptr <= 2'd0;
      end else if (accept_start) begin
         corner_ptr <= 2'd0;
      end else if (hs && corner_sel) begin
         corner_ptr <= corner_ptr + 2'd1;
      end
   end

   // A corner vector does not consume an LFSR value.
   assign lfsr_adv = hs && !corner_sel;
   assign in_flat  = corner_sel ? corner_pat : lfsr;
`else
   assign lfsr_adv = hs;
   assign in_flat  = lfsr;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is honoured only in IDLE.
   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_nxt    = (num_vec == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (last_hs) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered outputs, decoded from the upcoming state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         vec_valid <= (state_nxt == S_RUN);
         busy      <= (state_nxt == S_RUN);
         done      <= (state_nxt == S_DONE);
      end
   end

   // LFSR: seed loads in IDLE (zero guarded), steps on each non-corner handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED_SAFE;
      end else if ((state == S_IDLE) && seed_load) begin
         lfsr <= (seed == 34'h0) ? 34'h1 : seed;
      end else if (lfsr_adv) begin
         lfsr <= lfsr_step;
      end
   end

   // Run length is latched at start so mid-run num_vec changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_lat <= '0;
      end else if (accept_start) begin
         num_lat <= num_vec;
      end
   end

   // Accepted-vector count; cleared on start, held through DONE and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt <= '0;
      end else if (accept_start) begin
         vec_cnt <= '0;
      end else if (hs) begin
         vec_cnt <= vec_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fuzz_stim_gen.sv
module tb_fuzz_stim_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        seed_load;
   logic [33:0] seed;
   logic [15:0] num_vec;
   logic        vec_ready;
   logic        vec_valid;
   logic [33:0] in_flat;
   logic        busy;
   logic        done;
   logic [15:0] vec_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model state: what the generator's next LFSR value should be.
   logic [33:0] m_lfsr;

   fuzz_stim_gen #(.SEED(34'h1), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .seed_load (seed_load),
      .seed      (seed),
      .num_vec   (num_vec),
      .vec_ready (vec_ready),
      .vec_valid (vec_valid),
      .in_flat   (in_flat),
      .busy      (busy),
      .done      (done),
      .vec_cnt   (vec_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ld;
      logic [33:0] sd;
      int          n;
      int          pct;
      logic [33:0] first;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Polynomial step written from the tap list: x^34+x^27+x^2+x+1.
   function automatic logic [33:0] nxt(input logic [33:0] s);
      logic fb;
      fb = s[33] ^ s[26] ^ s[1] ^ s[0];
      return ((s << 1) & 34'h3_FFFF_FFFF) | {33'h0, fb};
   endfunction

   function automatic logic [33:0] adv(input logic [33:0] s, input int k);
      logic [33:0] r;
      r = s;
      for (int i = 0; i < k; i++) r = nxt(r);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One run: model produces the whole expected vector list up front, then the
   // bench consumes it with random backpressure and compares every cycle.
   task automatic do_run(input bit ld, input logic [33:0] sd, input int n, input int pct,
                         input bit chk_first, input logic [33:0] first);
      logic [33:0] exp_q[$];
      logic [33:0] corners[4];
      int ptr;
      int acc;
      int cyc;
      bit rdy;
      corners[0] = 34'h0_0000_0000;
      corners[1] = 34'h3_FFFF_FFFF;
      corners[2] = 34'h2_AAAA_AAAA;
      corners[3] = 34'h1_5555_5555;
      if (ld) m_lfsr = (sd == 34'h0) ? 34'h1 : sd;
      ptr = 0;
      for (int k = 0; k < n; k++) begin
`ifdef CORNER_INJECT_EN
         if ((k % 8) == 7) begin
            exp_q.push_back(corners[ptr % 4]);
            ptr++;
            continue;
         end
`endif
         exp_q.push_back(m_lfsr);
         m_lfsr = nxt(m_lfsr);
      end
      start = 1'b1; seed_load = ld; seed = sd; num_vec = n[15:0];
      tick();
      start = 1'b0; seed_load = 1'b0;
      if (n == 0) begin
         check("zero_run done", {63'h0, done}, 64'h1);
         check("zero_run valid", {63'h0, vec_valid}, 64'h0);
         check("zero_run cnt", {48'h0, vec_cnt}, 64'h0);
         tick();
         check("zero_run done clear", {63'h0, done}, 64'h0);
         return;
      end
      if (chk_first) check("run first vec", {30'h0, in_flat}, {30'h0, first});
      acc = 0;
      cyc = 0;
      while (acc < n && cyc < n * 50 + 20) begin
         check("run valid", {63'h0, vec_valid}, 64'h1);
         check("run busy", {63'h0, busy}, 64'h1);
         check("run no done", {63'h0, done}, 64'h0);
         check("run cnt", {48'h0, vec_cnt}, acc);
         check("run vec", {30'h0, in_flat}, {30'h0, exp_q[acc]});
         rdy = ($urandom_range(0, 99) < pct);
         vec_ready = rdy;
         num_vec = $urandom_range(0, 65535);
         tick();
         if (rdy) acc++;
         cyc++;
      end
      vec_ready = 1'b0;
      check("run accepted", acc, n);
      check("end done", {63'h0, done}, 64'h1);
      check("end valid", {63'h0, vec_valid}, 64'h0);
      check("end busy", {63'h0, busy}, 64'h0);
      check("end cnt", {48'h0, vec_cnt}, n);
      tick();
      check("idle done clear", {63'h0, done}, 64'h0);
      check("idle cnt hold", {48'h0, vec_cnt}, n);
   endtask

   initial begin
      vec_t tbl[5];
      logic [33:0] v[16];
      logic [33:0] e3[5];
      bit          r3[5];

      tbl[0] = '{ld: 1'b1, sd: 34'h0,           n: 5,  pct: 100, first: 34'h1};
      tbl[1] = '{ld: 1'b1, sd: 34'h2_DEAD_BEEF, n: 10, pct: 70,  first: 34'h2_DEAD_BEEF};
      tbl[2] = '{ld: 1'b1, sd: 34'h3_FFFF_FFFF, n: 3,  pct: 50,  first: 34'h3_FFFF_FFFF};
      tbl[3] = '{ld: 1'b0, sd: 34'h0,           n: 0,  pct: 100, first: 34'h0};
      tbl[4] = '{ld: 1'b1, sd: 34'h0_0000_00A5, n: 20, pct: 40,  first: 34'h0_0000_00A5};

      rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed = '0; num_vec = '0; vec_ready = 1'b0;
      repeat (3) tick();
      check("reset valid", {63'h0, vec_valid}, 64'h0);
      check("reset busy", {63'h0, busy}, 64'h0);
      check("reset done", {63'h0, done}, 64'h0);
      check("reset cnt", {48'h0, vec_cnt}, 64'h0);
      check("reset in_flat", {30'h0, in_flat}, 64'h1);
      rst_n = 1'b1;
      m_lfsr = 34'h1;
      tick();

      // Seed 1, four vectors at full rate, seed loaded together with start.
      start = 1'b1; seed_load = 1'b1; seed = 34'h1; num_vec = 16'd4; vec_ready = 1'b1;
      tick();
      start = 1'b0; seed_load = 1'b0;
      check("t1 vec0", {30'h0, in_flat}, 64'h1); tick();
      check("t1 vec1", {30'h0, in_flat}, 64'h3); tick();
      check("t1 vec2", {30'h0, in_flat}, 64'h6); tick();
      check("t1 vec3", {30'h0, in_flat}, 64'hD); tick();
      vec_ready = 1'b0;
      check("t1 done", {63'h0, done}, 64'h1);
      check("t1 cnt", {48'h0, vec_cnt}, 64'h4);
      tick();
      check("t1 done once", {63'h0, done}, 64'h0);
      m_lfsr = adv(34'h1, 4);

      // Seed load of zero alone in IDLE falls back to 1.
      seed_load = 1'b1; seed = 34'h0;
      tick();
      seed_load = 1'b0;
      check("t2 zero seed", {30'h0, in_flat}, 64'h1);
      m_lfsr = 34'h1;

      // Stall pattern 1,0,0,1,1; start/seed_load mid-run must be ignored.
      r3 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      e3 = '{34'h1, 34'h3, 34'h3, 34'h3, 34'h6};
      start = 1'b1; num_vec = 16'd3;
      tick();
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("t3 vec", {30'h0, in_flat}, {30'h0, e3[c]});
         check("t3 valid", {63'h0, vec_valid}, 64'h1);
         check("t3 no done", {63'h0, done}, 64'h0);
         start = (c == 1 || c == 2); seed_load = start; seed = 34'h5; num_vec = 16'd1;
         vec_ready = r3[c];
         tick();
      end
      start = 1'b0; seed_load = 1'b0; vec_ready = 1'b0;
      check("t3 done", {63'h0, done}, 64'h1);
      check("t3 cnt", {48'h0, vec_cnt}, 64'h3);
      tick();
      check("t3 done once", {63'h0, done}, 64'h0);
      m_lfsr = adv(34'h1, 3);

      // Reset in the middle of a run.
      start = 1'b1; seed_load = 1'b1; seed = 34'h1_2345_6789; num_vec = 16'd8; vec_ready = 1'b1;
      tick();
      start = 1'b0; seed_load = 1'b0;
      tick(); tick();
      check("t5 cnt before reset", {48'h0, vec_cnt}, 64'h2);
      rst_n = 1'b0;
      #1;
      check("t5 valid", {63'h0, vec_valid}, 64'h0);
      check("t5 busy", {63'h0, busy}, 64'h0);
      check("t5 in_flat", {30'h0, in_flat}, 64'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5 no done", {63'h0, done}, 64'h0);
      end
      rst_n = 1'b1; vec_ready = 1'b0;
      tick();
      check("t5 no done after", {63'h0, done}, 64'h0);
      m_lfsr = 34'h1;

`ifdef CORNER_INJECT_EN
      start = 1'b1; seed_load = 1'b1; seed = 34'h1; num_vec = 16'd16; vec_ready = 1'b1;
      tick();
      start = 1'b0; seed_load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         v[i] = in_flat;
         tick();
      end
      vec_ready = 1'b0;
      check("t6 vec7", {30'h0, v[7]}, 64'h0);
      check("t6 vec15", {30'h0, v[15]}, 64'h3_FFFF_FFFF);
      check("t6 vec8", {30'h0, v[8]}, {30'h0, nxt(v[6])});
      check("t6 vec6", {30'h0, v[6]}, {30'h0, adv(34'h1, 6)});
      check("t6 done", {63'h0, done}, 64'h1);
      tick();
      m_lfsr = adv(34'h1, 14);
`else
      v[0] = 34'h0;
`endif

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         do_run(tbl[i].ld, tbl[i].sd, tbl[i].n, tbl[i].pct, tbl[i].ld, tbl[i].first);
      end

      // Random runs against the model.
      for (int i = 0; i < 25; i++) begin
         logic [33:0] rs;
         bit          rl;
         rs = {$urandom_range(0, 3), $urandom};
         rl = ($urandom_range(0, 1) == 1);
         do_run(rl, rs, $urandom_range(0, 24), $urandom_range(30, 100), 1'b0, 34'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
